riscv_lsu: RTL

Load/store unit that initiates every access to the data memory port: it accepts one memory request at a time from the execute/memory stage over a valid/ready handshake. It sequences reads, writes and read-modify-write atomics (LR/SC/AMO) on the memory's wen/sel/addr/wdata/rdata interface, and returns sign- or zero-extended load data. It sits between the pipeline's memory stage and the data memory.

---
 rtl/riscv_pkg.sv | 58 +++++
 rtl/riscv_amo_alu.sv | 47 ++++
 rtl/riscv_lsu.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the load/store unit: commands, AMO opcodes, access sizes and FSM states.
package riscv_pkg;

    localparam int XLEN = 64;

    typedef enum logic [2:0] {
        CMD_LOAD  = 3'b000,
        CMD_STORE = 3'b001,
        CMD_LR    = 3'b010,
        CMD_SC    = 3'b011,
        CMD_AMO   = 3'b100
    } lsu_cmd_e;

    typedef enum logic [3:0] {
        AMO_SWAP = 4'd0,
        AMO_ADD  = 4'd1,
        AMO_XOR  = 4'd2,
        AMO_AND  = 4'd3,
        AMO_OR   = 4'd4,
        AMO_MIN  = 4'd5,
        AMO_MAX  = 4'd6,
        AMO_MINU = 4'd7,
        AMO_MAXU = 4'd8
    } amo_op_e;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Unknown encodings fall back to a plain load.
    function automatic lsu_cmd_e decode_cmd(input logic [2:0] raw);
        case (raw)
            3'b001:  decode_cmd = CMD_STORE;
            3'b010:  decode_cmd = CMD_LR;
            3'b011:  decode_cmd = CMD_SC;
            3'b100:  decode_cmd = CMD_AMO;
            default: decode_cmd = CMD_LOAD;
        endcase
    endfunction

    // Atomics need word/double size and natural alignment.
    function automatic logic atomic_fault(input logic [1:0] size, input logic [2:0] addr_lo);
        case (size)
            SIZE_W:  atomic_fault = (addr_lo[1:0] != 2'b00);
            SIZE_D:  atomic_fault = (addr_lo != 3'b000);
            default: atomic_fault = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/riscv_amo_alu.sv
// Combinational AMO datapath: computes the value written back for an atomic memory operation.
module riscv_amo_alu
    import riscv_pkg::*;
(
    input  logic [63:0] i_old,
    input  logic [63:0] i_operand,
    input  logic [3:0]  i_amo_op,
    input  logic        i_is_word,
    output logic [63:0] o_new
);

    logic [63:0] a_s;
    logic [63:0] b_s;
    logic [63:0] a_u;
    logic [63:0] b_u;
    logic        lt_s;
    logic        lt_u;
    logic [63:0] res;

    // Word operands are sign-extended for signed compares and zero-extended for unsigned ones,
    // so a single 64-bit comparator serves both widths.
    assign a_s  = i_is_word ? {{32{i_old[31]}}, i_old[31:0]} : i_old;
    assign b_s  = i_is_word ? {{32{i_operand[31]}}, i_operand[31:0]} : i_operand;
    assign a_u  = i_is_word ? {32'b0, i_old[31:0]} : i_old;
    assign b_u  = i_is_word ? {32'b0, i_operand[31:0]} : i_operand;
    assign lt_s = ($signed(a_s) < $signed(b_s));
    assign lt_u = (a_u < b_u);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        res = b_s;
        case (i_amo_op)
            AMO_SWAP: res = b_s;
            AMO_ADD:  res = a_s + b_s;
            AMO_XOR:  res = a_s ^ b_s;
            AMO_AND:  res = a_s & b_s;
            AMO_OR:   res = a_s | b_s;
            AMO_MIN:  res = lt_s ? a_s : b_s;
            AMO_MAX:  res = lt_s ? b_s : a_s;
            AMO_MINU: res = lt_u ? a_s : b_s;
            AMO_MAXU: res = lt_u ? b_s : a_s;
            default:  res = b_s;
        endcase
        o_new = i_is_word ? {{32{res[31]}}, res[31:0]} : res;
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: sequences loads, stores and LR/SC/AMO atomics on the data memory port,
// one request at a time, and returns extended load data or atomic status.
module riscv_lsu
    import riscv_pkg::*;
(
    input  logic        i_riscv_lsu_clk,
    input  logic        i_riscv_dm_rst,
    input  logic        i_riscv_lsu_req_valid,
    output logic        o_riscv_lsu_req_ready,
    input  logic [2:0]  i_riscv_lsu_cmd,
    input  logic [3:0]  i_riscv_lsu_amo_op,
    input  logic [1:0]  i_riscv_lsu_size,
    input  logic        i_riscv_lsu_unsigned,
    input  logic [63:0] i_riscv_lsu_addr,
    input  logic [63:0] i_riscv_lsu_wdata,
    output logic        o_riscv_lsu_resp_valid,
    output logic [63:0] o_riscv_lsu_resp_data,
    output logic        o_riscv_lsu_resp_fault,
    output logic        o_riscv_dm_wen,
    output logic [1:0]  o_riscv_dm_sel,
    output logic [63:0] o_riscv_dm_waddr,
    output logic [63:0] o_riscv_dm_wdata,
    input  logic [63:0] i_riscv_dm_rdata
);

    lsu_state_e  state_q, state_d;
    lsu_cmd_e    cmd_q, cmd_d;
    logic [3:0]  amo_op_q, amo_op_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic        fault_q, fault_d;
    logic        sc_miss_q, sc_miss_d;
    logic [63:0] rdata_q, rdata_d;
    logic        resv_valid_q, resv_valid_d;
    logic [63:0] resv_addr_q, resv_addr_d;

    lsu_cmd_e    req_cmd;
    logic        req_atomic;
    logic        req_fault;
    logic        req_sc_hit;
    logic        accept;
    logic [63:0] amo_new;
    logic [63:0] load_ext;
    logic [63:0] old_ext;
    logic [63:0] resp_data;

    riscv_amo_alu u_amo_alu (
        .i_old     (rdata_q),
        .i_operand (wdata_q),
        .i_amo_op  (amo_op_q),
        .i_is_word (size_q == SIZE_W),
        .o_new     (amo_new)
    );

    assign req_cmd    = decode_cmd(i_riscv_lsu_cmd);
    assign req_atomic = (req_cmd == CMD_LR) || (req_cmd == CMD_SC) || (req_cmd == CMD_AMO);
    assign req_fault  = req_atomic && atomic_fault(i_riscv_lsu_size, i_riscv_lsu_addr[2:0]);
    assign req_sc_hit = resv_valid_q && (resv_addr_q == i_riscv_lsu_addr);
    assign accept     = i_riscv_lsu_req_valid && o_riscv_lsu_req_ready;

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        amo_op_d     = amo_op_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        fault_d      = fault_q;
        sc_miss_d    = sc_miss_q;
        rdata_d      = rdata_q;
        resv_valid_d = resv_valid_q;
        resv_addr_d  = resv_addr_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    cmd_d      = req_cmd;
                    amo_op_d   = i_riscv_lsu_amo_op;
                    size_d     = i_riscv_lsu_size;
                    unsigned_d = i_riscv_lsu_unsigned;
                    addr_d     = i_riscv_lsu_addr;
                    wdata_d    = i_riscv_lsu_wdata;
                    fault_d    = req_fault;
                    sc_miss_d  = (req_cmd == CMD_SC) && !req_sc_hit;
                    if (req_cmd == CMD_SC) begin
                        resv_valid_d = 1'b0;
                    end
                    if (req_fault) begin
                        state_d = RESP;
                    end else begin
                        case (req_cmd)
                            CMD_STORE: state_d = WRITE;
                            CMD_SC:    state_d = req_sc_hit ? WRITE : RESP;
                            default:   state_d = READ;
                        endcase
                    end
                end
            end
            READ: begin
                rdata_d = i_riscv_dm_rdata;
                if (cmd_q == CMD_LR) begin
                    resv_valid_d = 1'b1;
                    resv_addr_d  = addr_q;
                end
                state_d = (cmd_q == CMD_AMO) ? WRITE : RESP;
            end
            WRITE: begin
                // A plain write or AMO landing on the reserved address breaks the LR/SC pair.
                if ((cmd_q == CMD_STORE || cmd_q == CMD_AMO) && resv_addr_q == addr_q) begin
                    resv_valid_d = 1'b0;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_riscv_lsu_clk or posedge i_riscv_dm_rst) begin
        if (i_riscv_dm_rst) begin
            state_q      <= IDLE;
            cmd_q        <= CMD_LOAD;
            amo_op_q     <= 4'd0;
            size_q       <= 2'd0;
            unsigned_q   <= 1'b0;
            addr_q       <= 64'd0;
            wdata_q      <= 64'd0;
            fault_q      <= 1'b0;
            sc_miss_q    <= 1'b0;
            rdata_q      <= 64'd0;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= 64'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            amo_op_q     <= amo_op_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            fault_q      <= fault_d;
            sc_miss_q    <= sc_miss_d;
            rdata_q      <= rdata_d;
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
        end
    end

    always_comb begin
        load_ext = rdata_q;
        case (size_q)
            SIZE_B:  load_ext = unsigned_q ? {56'b0, rdata_q[7:0]}  : {{56{rdata_q[7]}},  rdata_q[7:0]};
            SIZE_H:  load_ext = unsigned_q ? {48'b0, rdata_q[15:0]} : {{48{rdata_q[15]}}, rdata_q[15:0]};
            SIZE_W:  load_ext = unsigned_q ? {32'b0, rdata_q[31:0]} : {{32{rdata_q[31]}}, rdata_q[31:0]};
            default: load_ext = rdata_q;
        endcase
    end

    assign old_ext = (size_q == SIZE_W) ? {{32{rdata_q[31]}}, rdata_q[31:0]} : rdata_q;

    always_comb begin
        resp_data = 64'd0;
        if (!fault_q) begin
            case (cmd_q)
                CMD_LOAD:      resp_data = load_ext;
                CMD_LR,
                CMD_AMO:       resp_data = old_ext;
                CMD_SC:        resp_data = {63'd0, sc_miss_q};
                default:       resp_data = 64'd0;
            endcase
        end
    end

    assign o_riscv_lsu_req_ready  = (state_q == IDLE) && !i_riscv_dm_rst;
    assign o_riscv_lsu_resp_valid = (state_q == RESP);
    assign o_riscv_lsu_resp_data  = (state_q == RESP) ? resp_data : 64'd0;
    assign o_riscv_lsu_resp_fault = (state_q == RESP) && fault_q;

    assign o_riscv_dm_wen   = (state_q == WRITE) && !i_riscv_dm_rst;
    assign o_riscv_dm_sel   = size_q;
    assign o_riscv_dm_waddr = (state_q == READ || state_q == WRITE) ? addr_q : 64'd0;
    assign o_riscv_dm_wdata = (state_q != WRITE) ? 64'd0 :
                              (cmd_q == CMD_AMO) ? amo_new : wdata_q;

endmodule
